// File: rtl/bi_mem_reader.sv
// bi_mem_reader: streams NUM_WEIGHTS signed weights out of a dual-port weight bank.
// Lines are fetched two at a time (addr_a = 2k, addr_b = 2k+1), captured into buf0/buf1,
// then emitted lane by lane, most-significant lane first, over a valid/ready handshake.
// Optional feature: define BI_MEM_READER_SUM_EN to get a 32-bit running checksum on sum_out.
module bi_mem_reader #(
    parameter int ADDR_WIDTH   = 4,
    parameter int DATA_WIDTH   = 128,
    parameter int DEPTH        = 16,
    parameter int WEIGHT_WIDTH = 16,
    parameter int NUM_WEIGHTS  = 122
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    output logic [ADDR_WIDTH-1:0]   addr_a,
    output logic [ADDR_WIDTH-1:0]   addr_b,
    input  logic [DATA_WIDTH-1:0]   q_a,
    input  logic [DATA_WIDTH-1:0]   q_b,
    output logic [WEIGHT_WIDTH-1:0] w_data,
    output logic                    w_valid,
    input  logic                    w_ready,
    output logic                    w_last,
    output logic                    busy,
    output logic                    done,
    output logic [31:0]             sum_out
);

    localparam int LANES = DATA_WIDTH / WEIGHT_WIDTH;
    localparam int LANE_W = (2 * LANES > 1) ? $clog2(2 * LANES) : 1;
    localparam int IDX_W = $clog2(NUM_WEIGHTS + 1);

    localparam logic [1:0] StIdle   = 2'd0;
    localparam logic [1:0] StReq    = 2'd1;
    localparam logic [1:0] StCapt   = 2'd2;
    localparam logic [1:0] StStream = 2'd3;

    logic [1:0]              state_q, state_d;
    logic [ADDR_WIDTH-1:0]   addr_a_q, addr_a_d;
    logic [ADDR_WIDTH-1:0]   addr_b_q, addr_b_d;
    logic [ADDR_WIDTH-1:0]   k_q, k_d;
    logic [DATA_WIDTH-1:0]   buf0_q, buf0_d;
    logic [DATA_WIDTH-1:0]   buf1_q, buf1_d;
    logic [LANE_W-1:0]       lane_q, lane_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic                    busy_q, busy_d;
    logic                    done_q, done_d;

    logic                    buf1_en;
    logic                    is_last;
    logic                    start_acc;
    logic                    xfer;
    logic [ADDR_WIDTH-1:0]   k_inc;
    logic [DATA_WIDTH-1:0]   cur_line;
    logic [WEIGHT_WIDTH-1:0] w_data_c;
    int                      lane_sel;

    // Read address of line 2k, and of line 2k+1 clamped to the last bank line.
    function automatic logic [ADDR_WIDTH-1:0] addr_a_of(input logic [ADDR_WIDTH-1:0] k);
        return ADDR_WIDTH'(2 * int'(k));
    endfunction

    function automatic logic [ADDR_WIDTH-1:0] addr_b_of(input logic [ADDR_WIDTH-1:0] k);
        int b;
        b = 2 * int'(k) + 1;
        if (b > DEPTH - 1) b = DEPTH - 1;
        return ADDR_WIDTH'(b);
    endfunction

    assign k_inc     = k_q + 1'b1;
    // When the odd line of the pair lies past the bank, only buf0 lanes are emitted.
    assign buf1_en   = (2 * int'(k_q) + 1) < DEPTH;
    assign is_last   = (idx_q == IDX_W'(NUM_WEIGHTS - 1));
    assign start_acc = (state_q == StIdle) && start;
    assign xfer      = (state_q == StStream) && w_ready;

    // Lane mux: lanes 0..LANES-1 come from buf0, the rest from buf1, MSB lane first.
    always_comb begin
        lane_sel = int'(lane_q) % LANES;
        cur_line = (int'(lane_q) < LANES) ? buf0_q : buf1_q;
        w_data_c = cur_line[DATA_WIDTH - 1 - lane_sel * WEIGHT_WIDTH -: WEIGHT_WIDTH];
    end

    // Next-state logic for the fetch/capture/stream sequencer.
    always_comb begin
        state_d  = state_q;
        addr_a_d = addr_a_q;
        addr_b_d = addr_b_q;
        k_d      = k_q;
        buf0_d   = buf0_q;
        buf1_d   = buf1_q;
        lane_d   = lane_q;
        idx_d    = idx_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    k_d      = '0;
                    addr_a_d = addr_a_of('0);
                    addr_b_d = addr_b_of('0);
                    lane_d   = '0;
                    idx_d    = '0;
                    busy_d   = 1'b1;
                    state_d  = StReq;
                end
            end
            StReq: state_d = StCapt;
            StCapt: begin
                buf0_d  = q_a;
                buf1_d  = q_b;
                lane_d  = '0;
                state_d = StStream;
            end
            StStream: begin
                if (w_ready) begin
                    idx_d = idx_q + 1'b1;
                    if (is_last) begin
                        state_d = StIdle;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end else if (lane_q == (buf1_en ? LANE_W'(2 * LANES - 1)
                                                    : LANE_W'(LANES - 1))) begin
                        k_d      = k_inc;
                        addr_a_d = addr_a_of(k_inc);
                        addr_b_d = addr_b_of(k_inc);
                        lane_d   = '0;
                        state_d  = StReq;
                    end else begin
                        lane_d = lane_q + 1'b1;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= StIdle;
            addr_a_q <= '0;
            addr_b_q <= '0;
            k_q      <= '0;
            buf0_q   <= '0;
            buf1_q   <= '0;
            lane_q   <= '0;
            idx_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            addr_a_q <= addr_a_d;
            addr_b_q <= addr_b_d;
            k_q      <= k_d;
            buf0_q   <= buf0_d;
            buf1_q   <= buf1_d;
            lane_q   <= lane_d;
            idx_q    <= idx_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

`ifdef BI_MEM_READER_SUM_EN
    logic [31:0] sum_q, sum_d;

    // Wrapping checksum of sign-extended transferred weights.
    always_comb begin
        sum_d = sum_q;
        if (start_acc) sum_d = '0;
        else if (xfer) sum_d = sum_q + 32'($signed(w_data_c));
    end

    // Checksum register.
    always_ff @(posedge clk) begin
        if (reset) sum_q <= '0;
        else       sum_q <= sum_d;
    end

    assign sum_out = sum_q;
`else
    assign sum_out = '0;
`endif

    assign addr_a  = addr_a_q;
    assign addr_b  = addr_b_q;
    assign w_data  = w_data_c;
    assign w_valid = (state_q == StStream);
    assign w_last  = (state_q == StStream) && is_last;
    assign busy    = busy_q;
    assign done    = done_q;

endmodule

// File: tb/tb_bi_mem_reader.sv
// Self-checking bench for bi_mem_reader with a registered dual-port bank model.
// The expected weight stream is derived straight from the bank contents: weight i is
// lane (i % LANES) of line (i / LANES), most-significant lane first.
module tb_bi_mem_reader;

    localparam int AW    = 4;
    localparam int DW    = 128;
    localparam int DEPTH = 16;
    localparam int WW    = 16;
    localparam int NW    = 122;
    localparam int LANES = DW / WW;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          start = 1'b0;
    logic          w_ready = 1'b1;
    logic [AW-1:0] addr_a, addr_b;
    logic [DW-1:0] q_a = '0, q_b = '0;
    logic [WW-1:0] w_data;
    logic          w_valid, w_last, busy, done;
    logic [31:0]   sum_out;

    logic [DW-1:0] mem [DEPTH];

    int tests = 0;
    int fails = 0;

    bi_mem_reader #(
        .ADDR_WIDTH  (AW),
        .DATA_WIDTH  (DW),
        .DEPTH       (DEPTH),
        .WEIGHT_WIDTH(WW),
        .NUM_WEIGHTS (NW)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .addr_a (addr_a),
        .addr_b (addr_b),
        .q_a    (q_a),
        .q_b    (q_b),
        .w_data (w_data),
        .w_valid(w_valid),
        .w_ready(w_ready),
        .w_last (w_last),
        .busy   (busy),
        .done   (done),
        .sum_out(sum_out)
    );

    always #5 clk = ~clk;

    // Bank: read data appears one cycle after the address.
    always @(posedge clk) begin
        q_a <= mem[addr_a];
        q_b <= mem[addr_b];
    end

    int cyc = 0;

    function automatic logic [WW-1:0] model_w(input int i);
        int line, lane;
        logic [DW-1:0] l;
        line = i / LANES;
        lane = i % LANES;
        l = mem[line];
        return l[DW - 1 - lane * WW -: WW];
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor state
    int             idx = 0;
    int             done_cnt = 0;
    int             gap = 0;
    bit             run_active = 0;
    bit             prev_reset = 0;
    bit             prev_stall = 0;
    bit             prev_lastxfer = 0;
    logic [WW-1:0]  prev_data = '0;
    logic           prev_last = 1'b0;
    logic [WW-1:0]  got [NW];

    // Compare process: outputs sampled on the falling edge against the model.
    always @(negedge clk) begin
        cyc++;
        if (prev_reset) begin
            chk("reset_outs", {addr_a, addr_b, w_data, w_valid, w_last, busy, done}, 64'd0);
            chk("reset_sum", sum_out, 0);
        end
        if (reset) begin
            run_active    = 0;
            prev_stall    = 0;
            prev_lastxfer = 0;
            gap           = 0;
            prev_reset    = 1;
        end else begin
            prev_reset = 0;
            chk("busy", busy, run_active);
`ifndef BI_MEM_READER_SUM_EN
            chk("sum_zero", sum_out, 0);
`endif
            if (done) begin
                done_cnt++;
                chk("done_after_last", prev_lastxfer, 1);
            end
            if (gap != 0) begin
                gap--;
                chk(gap == 0 ? "valid_latency" : "gap_idle", w_valid, gap == 0);
            end
            if (prev_stall) begin
                chk("stall_valid", w_valid, 1);
                chk("stall_data", w_data, prev_data);
                chk("stall_last", w_last, prev_last);
            end
            if (w_valid) begin
                if (!run_active || idx >= NW) chk("spurious_valid", w_valid, 0);
                else begin
                    chk("w_data", w_data, model_w(idx));
                    chk("w_last", w_last, idx == NW - 1);
                end
            end else begin
                chk("w_last_idle", w_last, 0);
            end
            prev_stall    = w_valid && !w_ready;
            prev_data     = w_data;
            prev_last     = w_last;
            prev_lastxfer = 0;
            if (w_valid && w_ready && run_active && idx < NW) begin
                got[idx] = w_data;
                idx++;
                if (idx == NW) begin
                    run_active    = 0;
                    prev_lastxfer = 1;
                end else if (idx % (2 * LANES) == 0) begin
                    gap = 3;
                end
            end
            if (start && !busy) begin
                idx        = 0;
                run_active = 1;
                gap        = 3;
            end
        end
    end

    // Backpressure generator; one 5-cycle stall in the middle of a line.
    int bp_mode = 0;
    int hold = 0;
    bit held = 0;
    always @(posedge clk) begin
        #1;
        if (bp_mode == 0) begin
            w_ready = 1'b1;
        end else if (hold > 0) begin
            w_ready = 1'b0;
            hold--;
        end else if (!held && idx >= 20) begin
            held    = 1;
            hold    = 4;
            w_ready = 1'b0;
        end else begin
            w_ready = 1'($urandom_range(0, 1));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idx(input int target, input int budget);
        int n = 0;
        while (idx < target && n < budget) begin
            step();
            n++;
        end
        chk("wait_idx_timeout", idx >= target, 1);
    endtask

    task automatic wait_done(input int budget);
        int n = 0;
        int d0 = done_cnt;
        while (done_cnt == d0 && n < budget) begin
            step();
            n++;
        end
        chk("wait_done_timeout", done_cnt > d0, 1);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic check_literals(input string tag);
        chk({tag, "_w0"}, got[0], 16'hf6cf);
        chk({tag, "_w1"}, got[1], 16'hf317);
        chk({tag, "_w8"}, got[8], 16'hf81f);
        chk({tag, "_w120"}, got[120], 16'h0a68);
        chk({tag, "_w121"}, got[121], 16'h0611);
    endtask

    int d0;
    logic [31:0] exp_sum;

    initial begin
        for (int i = 0; i < DEPTH; i++) begin
            mem[i] = {$urandom, $urandom, $urandom, $urandom};
        end
        mem[0][127:112]  = 16'hf6cf;
        mem[0][111:96]   = 16'hf317;
        mem[1][127:112]  = 16'hf81f;
        mem[15][127:112] = 16'h0a68;
        mem[15][111:96]  = 16'h0611;

        // Reset held 3 cycles with start asserted.
        reset = 1'b1;
        start = 1'b1;
        repeat (3) step();
        reset = 1'b0;
        start = 1'b0;
        repeat (2) step();
        chk("idle_busy", busy, 0);

        // Full run, w_ready tied high.
        d0 = done_cnt;
        pulse_start();
        wait_done(400);
        chk("run1_count", idx, NW);
        check_literals("run1");
        exp_sum = '0;
        for (int i = 0; i < NW; i++) exp_sum += 32'($signed(model_w(i)));
`ifdef BI_MEM_READER_SUM_EN
        chk("sum_out", sum_out, exp_sum);
`else
        chk("sum_out_off", sum_out, 0);
`endif
        repeat (3) step();
        chk("run1_one_done", done_cnt - d0, 1);

        // Random backpressure.
        bp_mode = 1;
        d0 = done_cnt;
        pulse_start();
        wait_done(3000);
        bp_mode = 0;
        chk("bp_count", idx, NW);
        check_literals("bp");
        repeat (3) step();
        chk("bp_one_done", done_cnt - d0, 1);

        // Start while busy is ignored.
        d0 = done_cnt;
        pulse_start();
        wait_idx(40, 400);
        pulse_start();
        wait_done(400);
        chk("busy_start_count", idx, NW);
        repeat (5) step();
        chk("busy_start_one_done", done_cnt - d0, 1);
        chk("busy_start_idle", busy, 0);

        // Start held through the done cycle starts a new run immediately.
        d0 = done_cnt;
        pulse_start();
        wait_idx(NW - 1, 400);
        start = 1'b1;
        wait_done(400);
        start = 1'b0;
        chk("back2back_restart", busy, 1);
        wait_done(400);
        chk("back2back_count", idx, NW);
        chk("back2back_dones", done_cnt - d0, 2);
        check_literals("b2b");

        // Reset mid-run aborts without done, then a fresh run restarts at weight 0.
        pulse_start();
        wait_idx(60, 400);
        d0 = done_cnt;
        reset = 1'b1;
        repeat (2) step();
        reset = 1'b0;
        repeat (20) step();
        chk("abort_no_done", done_cnt - d0, 0);
        pulse_start();
        wait_idx(1, 50);
        chk("restart_w0", got[0], 16'hf6cf);
        wait_done(400);
        chk("restart_count", idx, NW);
        chk("restart_one_done", done_cnt - d0, 1);
`ifdef BI_MEM_READER_SUM_EN
        chk("restart_sum", sum_out, exp_sum);
`endif

        repeat (3) step();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    // Absolute watchdog.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/bi_mem_reader.md
BI_MEM_READER -- requirements
Module: bi_mem_reader

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 4, meaning the bank address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 128, meaning the bank line width.
REQ-003 SHALL have parameter DEPTH, default 16, meaning the number of bank lines.
REQ-004 SHALL have parameter WEIGHT_WIDTH, default 16, meaning the width of one signed weight; LANES = DATA_WIDTH/WEIGHT_WIDTH.
REQ-005 SHALL have parameter NUM_WEIGHTS, default 122, meaning the number of weights streamed per run; legal range 1..DEPTH*LANES.
REQ-006 SHALL have port clk, input, 1 bit: the single clock, all logic on posedge.
REQ-007 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-008 SHALL have port start, input, 1 bit: begins one readout run when sampled high in IDLE.
REQ-009 SHALL have ports addr_a and addr_b, output, ADDR_WIDTH each: registered read addresses to the dual-port bank.
REQ-010 SHALL have ports q_a and q_b, input, DATA_WIDTH each: bank read data, valid one cycle after the address is presented.
REQ-011 SHALL have port w_data, output, WEIGHT_WIDTH: current weight.
REQ-012 SHALL have port w_valid, output, 1 bit; w_ready, input, 1 bit; w_last, output, 1 bit, high with the final weight.
REQ-013 SHALL have port busy, output, 1 bit; done, output, 1 bit, one-cycle pulse.
REQ-014 SHALL have port sum_out, output, 32 bits: weight checksum (see Configuration).

Function
REQ-015 SHALL implement states IDLE, REQ, CAPT, STREAM.
REQ-016 In IDLE, start=1 SHALL load addr_a=2k, addr_b=2k+1 (k = pair index, 0 on start), clear counters, set busy, and enter REQ.
REQ-017 REQ SHALL last exactly one cycle, with the bank sampling addr_a/addr_b; next state CAPT.
REQ-018 CAPT SHALL register q_a into buf0 and q_b into buf1; next state STREAM.
REQ-019 STREAM SHALL present the buf0 lanes, then the buf1 lanes, most-significant lane first (bits DATA_WIDTH-1 down to DATA_WIDTH-WEIGHT_WIDTH first).
REQ-020 A weight transfers only on a cycle with w_valid=1 and w_ready=1; while w_ready=0, w_data, w_last and w_valid SHALL hold stable.
REQ-021 After 2*LANES transfers with weights remaining, the block SHALL increment k, update addresses, and return to REQ; w_valid=0 in REQ and CAPT.
REQ-022 The first w_valid SHALL assert 3 cycles after start is sampled; steady-state throughput is 2*LANES weights per 2*LANES+2 cycles.
REQ-023 When 2k+1 >= DEPTH, addr_b SHALL be held at DEPTH-1 and no buf1 lane is emitted.
REQ-024 w_last SHALL be high exactly on weight index NUM_WEIGHTS-1; lanes beyond it are never emitted.
REQ-025 On the last transfer the block SHALL enter IDLE; done SHALL pulse the following cycle, and busy SHALL fall in that same cycle.
REQ-026 start while busy=1 SHALL be ignored.
REQ-027 start coincident with the done cycle SHALL begin a new run normally, because the block is in IDLE.

Reset
REQ-028 reset=1 SHALL force IDLE, and drive addr_a=0, addr_b=0, w_data=0, w_valid=0, w_last=0, busy=0, done=0, sum_out=0, buf0=buf1=0, with all counters at 0.
REQ-029 reset SHALL take priority over start and over an in-flight transfer; reset mid-run SHALL abort the run with no done pulse.

Configuration
REQ-030 With macro BI_MEM_READER_SUM_EN defined, sum_out SHALL be a 32-bit wrapping sum of the sign-extended transferred weights, cleared on accepted start and updated on each transfer.
REQ-031 With BI_MEM_READER_SUM_EN undefined, sum_out SHALL be constant 0 and no accumulator logic is present.

Verification
REQ-032 Reset: hold reset 3 cycles with start=1 -> all outputs 0, busy stays 0.
REQ-033 Full run: bi_mem0 attached, w_ready=1, start pulse -> exactly 122 transfers.
  - Weights 0, 1 and 8 are 16'hf6cf, 16'hf317 and 16'hf81f.
  - Weights 120 and 121 are 16'h0a68 and 16'h0611, with w_last only on 16'h0611.
  - done pulses once, one cycle after weight 121.
REQ-034 Backpressure: w_ready toggled pseudo-randomly, including held low 5 cycles mid-line -> identical 122-weight sequence, and w_data stable while stalled.
REQ-035 Start while busy: second start at transfer 40 -> ignored, still 122 transfers and one done.
REQ-036 Reset mid-run: reset at transfer 60, then new start -> no done from the aborted run, and the new run restarts at 16'hf6cf.
REQ-037 With BI_MEM_READER_SUM_EN: after the full run, sum_out equals the bench-model 32-bit sum of the 122 sign-extended weights; without the macro, sum_out=0 throughout.
